// File: rtl/bus_trace_capture.sv
// 6502 bus trace capture: latches {addr,data} on qualified opcode fetches and drives six hex digits.
// Optional macro TRACE_HISTORY_EN adds an 8-entry circular history with button browsing.
module bus_trace_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_in,
    input  logic [7:0]  data_in,
    input  logic        sync_in,
    input  logic        cap_mode,
    input  logic        arm_in,
    input  logic        freeze_in,
    input  logic        browse_in,
    output logic [3:0]  digit5,
    output logic [3:0]  digit4,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic        valid_out,
    output logic [3:0]  entries_out,
    output logic [2:0]  sel_out,
    output logic        armed_out
);

    logic [23:0] disp_reg;
    logic [3:0]  entries_reg, entries_next;
    logic [2:0]  sel_reg, sel_next;
    logic        armed_reg, armed_next;
    logic        capture;

    assign capture = sync_in & ~freeze_in & (~cap_mode | armed_reg);

    // An arm pulse wins over the clear caused by a mode-1 capture in the same cycle.
    always_comb begin
        armed_next = armed_reg;
        if (arm_in)
            armed_next = 1'b1;
        else if (capture && cap_mode)
            armed_next = 1'b0;
    end

`ifdef TRACE_HISTORY_EN
    logic [23:0] mem [0:7];
    logic [2:0]  wr_ptr_reg, wr_ptr_next, rd_idx;
    logic        browse_prev_reg;
    logic        browse_edge;

    assign browse_edge = browse_in & ~browse_prev_reg;

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        entries_next = entries_reg;
        sel_next     = sel_reg;
        if (capture) begin
            wr_ptr_next = wr_ptr_reg + 3'd1;
            if (entries_reg != 4'd8)
                entries_next = entries_reg + 4'd1;
            sel_next = 3'd0;
        end else if (browse_edge && entries_reg > 4'd1) begin
            if ({1'b0, sel_reg} + 4'd1 == entries_reg)
                sel_next = 3'd0;
            else
                sel_next = sel_reg + 3'd1;
        end
        // Index of the entry to show after this edge when no capture is writing.
        rd_idx = wr_ptr_reg - 3'd1 - sel_next;
    end

    always_ff @(posedge clk) begin
        if (capture && !rst)
            mem[wr_ptr_reg] <= {addr_in, data_in};
    end

    // Registered RAM read; a capture bypasses the RAM so it shows one cycle later.
    always_ff @(posedge clk) begin
        if (rst)
            disp_reg <= 24'd0;
        else if (capture)
            disp_reg <= {addr_in, data_in};
        else if (entries_reg == 4'd0)
            disp_reg <= 24'd0;
        else
            disp_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= 3'd0;
            browse_prev_reg <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            browse_prev_reg <= browse_in;
        end
    end
`else
    wire unused_browse = browse_in;

    always_comb begin
        entries_next = entries_reg;
        sel_next     = 3'd0;
        if (capture)
            entries_next = 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            disp_reg <= 24'd0;
        else if (capture)
            disp_reg <= {addr_in, data_in};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_reg <= 4'd0;
            sel_reg     <= 3'd0;
            armed_reg   <= 1'b0;
        end else begin
            entries_reg <= entries_next;
            sel_reg     <= sel_next;
            armed_reg   <= armed_next;
        end
    end

    logic [3:0] nib [0:5];

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_nib
            assign nib[gi] = disp_reg[gi*4 +: 4];
        end
    endgenerate

    assign digit0      = nib[0];
    assign digit1      = nib[1];
    assign digit2      = nib[2];
    assign digit3      = nib[3];
    assign digit4      = nib[4];
    assign digit5      = nib[5];
    assign valid_out   = (entries_reg != 4'd0);
    assign entries_out = entries_reg;
    assign sel_out     = sel_reg;
    assign armed_out   = armed_reg;

endmodule

// File: tb/tb_bus_trace_capture.sv
// Randomized self-checking bench for bus_trace_capture against a newest-first history model.
// Follows the DUT build: define TRACE_HISTORY_EN for both to exercise the history.
module tb_bus_trace_capture;

`ifdef TRACE_HISTORY_EN
    localparam int DEPTH = 8;
    localparam bit HIST  = 1'b1;
`else
    localparam int DEPTH = 1;
    localparam bit HIST  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'd0;
    logic [7:0]  data = 8'd0;
    logic        sync = 1'b0;
    logic        mode = 1'b0;
    logic        arm = 1'b0;
    logic        freeze = 1'b0;
    logic        browse = 1'b0;
    logic [3:0]  digit5, digit4, digit3, digit2, digit1, digit0;
    logic        valid_out;
    logic [3:0]  entries_out;
    logic [2:0]  sel_out;
    logic        armed_out;

    bus_trace_capture dut (
        .clk         (clk),
        .rst         (rst),
        .addr_in     (addr),
        .data_in     (data),
        .sync_in     (sync),
        .cap_mode    (mode),
        .arm_in      (arm),
        .freeze_in   (freeze),
        .browse_in   (browse),
        .digit5      (digit5),
        .digit4      (digit4),
        .digit3      (digit3),
        .digit2      (digit2),
        .digit1      (digit1),
        .digit0      (digit0),
        .valid_out   (valid_out),
        .entries_out (entries_out),
        .sel_out     (sel_out),
        .armed_out   (armed_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: hist[0] is the newest capture; the display shows hist[m_sel].
    logic [23:0] hist[$];
    int          m_sel   = 0;
    bit          m_armed = 1'b0;
    bit          m_prev  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [23:0] digits();
        return {digit5, digit4, digit3, digit2, digit1, digit0};
    endfunction

    // Advance one clock with the currently driven inputs, update the model, compare outputs.
    task automatic tick();
        bit          cap;
        bit          edge_seen;
        logic [23:0] exp_d;
        cap = sync && !freeze && (!mode || m_armed);
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
            m_sel   = 0;
            m_armed = 1'b0;
            m_prev  = 1'b0;
        end else begin
            edge_seen = browse && !m_prev;
            m_prev    = browse;
            if (arm)
                m_armed = 1'b1;
            else if (cap && mode)
                m_armed = 1'b0;
            if (cap) begin
                hist.push_front({addr, data});
                if (hist.size() > DEPTH)
                    void'(hist.pop_back());
                m_sel = 0;
                $display("capture addr=%04h data=%02h entries=%0d", addr, data, hist.size());
            end else if (HIST && edge_seen && hist.size() >= 2) begin
                m_sel = (m_sel + 1) % hist.size();
            end
        end
        exp_d = (hist.size() != 0) ? hist[m_sel] : 24'd0;
        check("digits",  digits(),    exp_d);
        check("valid",   valid_out,   (hist.size() != 0));
        check("entries", entries_out, hist.size());
        check("sel",     sel_out,     m_sel);
        check("armed",   armed_out,   m_armed);
    endtask

    task automatic idle();
        sync = 1'b0; arm = 1'b0; rst = 1'b0;
    endtask

    initial begin
        logic [23:0] e;
        int          j;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_digits", digits(), 24'd0);
        check("rst_entries", entries_out, 4'd0);
        idle();
        tick();

        // Mode 0 single capture
        mode = 1'b0; sync = 1'b1; addr = 16'hC012; data = 8'hA9;
        tick();
        idle();
        check("m0_digits", digits(), 24'hC012A9);
        check("m0_entries", entries_out, 4'd1);
        tick();

        // Mode 1: sync without arm is ignored, armed sync captures and disarms
        mode = 1'b1; sync = 1'b1; addr = 16'h1234; data = 8'h56;
        tick();
        check("m1_noarm", digits(), 24'hC012A9);
        sync = 1'b0; arm = 1'b1;
        tick();
        check("m1_armed", armed_out, 1'b1);
        arm = 1'b0; sync = 1'b1; addr = 16'hFFFC; data = 8'h4C;
        tick();
        idle();
        check("m1_digits", digits(), 24'hFFFC4C);
        check("m1_disarm", armed_out, 1'b0);

        // Ten captures then browse through the history
        mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sync = 1'b1; addr = 16'(i); data = 8'(i);
            tick();
        end
        idle();
        tick();
        check("wrap_entries", entries_out, 4'(DEPTH));
        check("wrap_newest", digits(), 24'h000909);
        for (int k = 1; k <= 8; k++) begin
            browse = 1'b1;
            tick();
            j = HIST ? ((k < 8) ? 9 - k : 9) : 9;
            e = {j[15:0], j[7:0]};
            check("browse_step", digits(), e);
            browse = 1'b0;
            tick();
        end

        // Freeze blocks captures but not browsing
        freeze = 1'b1; sync = 1'b1; addr = 16'hBEEF; data = 8'h11;
        tick();
        check("frz_entries", entries_out, 4'(DEPTH));
        sync = 1'b0; browse = 1'b1;
        tick();
        check("frz_browse", sel_out, HIST ? 3'd1 : 3'd0);
        browse = 1'b0; freeze = 1'b0;
        tick();

        // Same-cycle capture, browse edge and arm in mode 1
        mode = 1'b1; arm = 1'b1;
        tick();
        sync = 1'b1; arm = 1'b1; browse = 1'b1; addr = 16'h4321; data = 8'h77;
        tick();
        idle(); browse = 1'b0;
        check("combo_sel", sel_out, 3'd0);
        check("combo_armed", armed_out, 1'b1);
        check("combo_digits", digits(), 24'h432177);

        // Reset coincident with a capture
        mode = 1'b0; sync = 1'b1; rst = 1'b1; addr = 16'h5555; data = 8'h55;
        tick();
        idle();
        check("rstcap_digits", digits(), 24'd0);
        check("rstcap_valid", valid_out, 1'b0);
        check("rstcap_entries", entries_out, 4'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 99) == 0);
            sync   = ($urandom_range(0, 2) == 0);
            arm    = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) browse = ~browse;
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            addr = 16'($urandom);
            data = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_trace_capture.md
BUS_TRACE_CAPTURE -- requirements
Module: bus_trace_capture

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 The ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr_in  in  16  6502 address bus
- data_in  in  8  6502 data bus
- sync_in  in  1  opcode-fetch qualifier; capture candidate when 1
- cap_mode  in  1  0 = capture every qualified cycle, 1 = capture only when armed
- arm_in  in  1  single-cycle arm pulse, used in mode 1
- freeze_in  in  1  level; 1 blocks all captures
- browse_in  in  1  externally debounced button level; rising edge steps history
- digit5..digit0  out  4 each  nibbles for six downstream hex-to-7-segment decoders
- valid_out  out  1  1 when the displayed entry holds captured data
- entries_out  out  4  number of stored entries, 0..8
- sel_out  out  3  browse index; 0 = newest entry
- armed_out  out  1  arm flag

Function
REQ-003 A capture SHALL occur in any cycle where sync_in=1, freeze_in=0, and either cap_mode=0 or the armed flag is 1.
REQ-004 A capture SHALL store the pair {addr_in, data_in}; the captured value SHALL appear on the digits the cycle after the capture edge (1-cycle latency).
REQ-005 Digit mapping SHALL be: digit5..digit2 = addr[15:12], addr[11:8], addr[7:4], addr[3:0]; digit1 = data[7:4]; digit0 = data[3:0].
REQ-006 An arm_in=1 SHALL set the armed flag; a capture in mode 1 SHALL clear it.
REQ-007 When a capture clears the flag and arm_in=1 in the same cycle, the flag SHALL end at 1 (set wins); only one capture SHALL occur.
REQ-008 The history SHALL be a circular buffer of 8 entries.
REQ-009 The write pointer SHALL wrap from 7 to 0, overwriting the oldest entry.
REQ-010 entries_out SHALL increment per capture and saturate at 8.
REQ-011 The displayed entry SHALL be index (wr_ptr - 1 - sel_out) mod 8.
REQ-012 A browse_in rising edge (browse_in=1 with the previous sample 0) SHALL set sel_out to (sel_out+1) mod entries_out.
REQ-013 Browse edges SHALL be ignored when entries_out is 0 or 1.
REQ-014 Every capture SHALL force sel_out to 0; a capture and a browse edge in the same cycle SHALL yield sel_out=0.
REQ-015 With entries_out=0, digits SHALL be 0 and valid_out SHALL be 0; otherwise valid_out SHALL be 1.
REQ-016 freeze_in SHALL block captures only; browsing SHALL remain active while frozen.

Reset
REQ-017 The following SHALL all clear to 0 on rst=1: digits, valid_out, entries_out, sel_out, armed flag, write pointer, and the browse edge-detect register.
REQ-018 rst SHALL take priority over any capture, arm, or browse event in the same cycle.
REQ-019 Buffer RAM contents need not clear, but SHALL be unobservable until rewritten.

Configuration
REQ-020 With macro TRACE_HISTORY_EN defined, REQ-008 to REQ-014 SHALL apply.
REQ-021 Without TRACE_HISTORY_EN:
- storage SHALL be a single register;
- entries_out SHALL saturate at 1;
- sel_out SHALL be tied to 0;
- browse_in SHALL be ignored;
- each capture SHALL overwrite the register.

Verification
REQ-022 Mode 0, sync_in=1 with addr=0xC012, data=0xA9 for 1 cycle -> next cycle digits = C,0,1,2,A,9, valid_out=1, entries_out=1.
REQ-023 Mode 1, sync pulse without arm -> no capture; arm_in pulse, then sync with 0xFFFC/0x4C -> captured, armed_out returns to 0.
REQ-024 Ten captures with addr 0x0000..0x0009 -> entries_out=8; browse edges step the display 0x0009, 0x0008 ... 0x0002, then back to 0x0009.
REQ-025 freeze_in=1 during sync cycles -> digits unchanged, entries_out unchanged; browse still steps sel_out.
REQ-026 Same-cycle capture, browse edge, and arm_in in mode 1 -> sel_out=0, armed_out=1, exactly one new entry.
REQ-027 Assert rst coincident with a capture -> entries_out=0, digits=0, valid_out=0 on the next cycle.
